// File: rtl/bamf_mem_pkg.sv
// Shared definitions for the byte/halfword load path: FSM state encodings,
// the default read timeout, and the byte order used to assemble halfwords.
package bamf_mem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD_LO = 2'd1;
    localparam logic [1:0] ST_RD_HI = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WAIT_MAX_DEFAULT = 15;

    // Halfwords are stored with the low byte at the lower address.
    localparam bit LITTLE_ENDIAN = 1'b1;

    // Combine the first-read and second-read bytes into a halfword.
    function automatic logic [15:0] assemble_half(input logic [7:0] first_byte,
                                                  input logic [7:0] second_byte);
        if (LITTLE_ENDIAN)
            return {second_byte, first_byte};
        else
            return {first_byte, second_byte};
    endfunction

endpackage

// File: rtl/byte_load_sequencer_extender.sv
// byte_extender: widens one byte to 16 bits, either zero- or sign-extended.
// Purely combinational.
module byte_extender (
    input  logic [7:0]  byte_in,
    input  logic        sign_sel,
    output logic [15:0] word_out
);

    // Replicate bit 7 into the upper byte only when sign extension is selected.
    always_comb begin
        word_out = {{8{sign_sel & byte_in[7]}}, byte_in};
    end

endmodule

// File: rtl/byte_load_sequencer.sv
// byte_load_sequencer: turns a byte or halfword load request into one or two
// 8-bit memory reads, with a per-read timeout.  Outputs depend only on state
// and registers, never directly on inputs.
// Optional feature: define LD_SIGN_EXT_EN to add the ld_signed port and allow
// sign-extended byte loads; without it byte loads are always zero-extended.
module byte_load_sequencer
    import bamf_mem_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_word,
    input  logic [ADDR_W-1:0] ld_addr,
`ifdef LD_SIGN_EXT_EN
    input  logic              ld_signed,
`endif
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [15:0]       ld_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    logic [1:0]        state;
    logic              word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        lo_q;
    logic [7:0]        hi_q;
    logic              err_q;
    logic [7:0]        wait_cnt;
    logic [15:0]       data_hold;
    logic              sign_sel;
    logic [15:0]       ext_out;
    logic [15:0]       done_val;

`ifdef LD_SIGN_EXT_EN
    logic              sign_q;

    // Remember the extension mode of the accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sign_q <= 1'b0;
        else if (state == ST_IDLE && ld_start)
            sign_q <= ld_signed;
    end

    assign sign_sel = sign_q;
`else
    assign sign_sel = 1'b0;
`endif

    byte_extender u_ext (
        .byte_in  (lo_q),
        .sign_sel (sign_sel),
        .word_out (ext_out)
    );

    // Load sequencing FSM.  A read waits at most WAIT_MAX cycles without an
    // ack; an ack arriving in the cycle the counter sits at the limit still
    // completes normally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_q    <= 1'b0;
            addr_q    <= '0;
            lo_q      <= 8'h00;
            hi_q      <= 8'h00;
            err_q     <= 1'b0;
            wait_cnt  <= 8'h00;
            data_hold <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_start) begin
                        word_q   <= ld_word;
                        addr_q   <= ld_addr;
                        err_q    <= 1'b0;
                        wait_cnt <= 8'h00;
                        state    <= ST_RD_LO;
                    end
                end
                ST_RD_LO: begin
                    if (mem_ack) begin
                        lo_q     <= mem_rdata;
                        wait_cnt <= 8'h00;
                        state    <= word_q ? ST_RD_HI : ST_DONE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RD_HI: begin
                    if (mem_ack) begin
                        hi_q  <= mem_rdata;
                        state <= ST_DONE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    data_hold <= done_val;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Result presented during DONE: zero on timeout, else halfword or extended byte.
    always_comb begin
        done_val = 16'h0000;
        if (!err_q)
            done_val = word_q ? assemble_half(lo_q, hi_q) : ext_out;
    end

    // Status and memory-side outputs decoded from state and registers only.
    always_comb begin
        ld_busy  = (state != ST_IDLE);
        ld_done  = (state == ST_DONE);
        ld_err   = (state == ST_DONE) & err_q;
        ld_data  = (state == ST_DONE) ? done_val : data_hold;
        mem_req  = (state == ST_RD_LO) || (state == ST_RD_HI);
        mem_addr = '0;
        if (state == ST_RD_LO)
            mem_addr = addr_q;
        else if (state == ST_RD_HI)
            mem_addr = addr_q + ADDR_W'(1);
    end

endmodule

// File: doc/byte_load_sequencer.md
# byte_load_sequencer

Sequences byte and halfword loads from the processor's 8-bit data memory port into the 16-bit register-file write path. A halfword load takes two byte reads, little-endian. A byte load takes one read and is widened to 16 bits through an extender sub-module. The block sits between the control unit's load request and the memory interface, and enforces a per-read timeout so a stalled memory cannot hang the core.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- WAIT_MAX, 15, max cycles a read may wait for mem_ack before abort (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_start  in  1  load request; sampled only in IDLE
- ld_word  in  1  1 = 16-bit load, 0 = byte load; sampled with ld_start
- ld_addr  in  ADDR_W  load address; sampled with ld_start
- ld_signed  in  1  sign-extend byte load; present only with LD_SIGN_EXT_EN
- ld_busy  out  1  high in every non-IDLE state
- ld_done  out  1  one-cycle completion pulse
- ld_err  out  1  timeout flag; valid only with ld_done
- ld_data  out  16  loaded value; holds until next ld_done
- mem_req  out  1  read request to memory
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  8  read data; valid when mem_ack=1
- mem_ack  in  1  read complete

## Operation
- States: IDLE, RD_LO, RD_HI, DONE.
- IDLE:
  - On ld_start, latch ld_word, ld_addr (and ld_signed), then go to RD_LO.
  - ld_start is ignored in every other state, including DONE.
- RD_LO:
  - mem_req=1, mem_addr=addr.
  - On mem_ack, capture mem_rdata as the low byte.
  - If word, go to RD_HI; otherwise go to DONE.
- RD_HI:
  - mem_req=1, mem_addr=addr+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - On mem_ack, capture the high byte, then go to DONE.
- DONE:
  - ld_done=1 and ld_data updated, both in this cycle.
  - Always go to IDLE next.
- ld_data by load type:
  - Byte load: extender output of the low byte.
  - Word load: {hi, lo}.
- Timeout:
  - A wait counter clears on entry to RD_LO and to RD_HI, and increments each cycle mem_ack=0.
  - If the counter reaches WAIT_MAX without an ack: go to DONE with ld_err=1 and ld_data=16'h0000.
  - mem_ack in the same cycle the limit is reached wins: no error.
- mem_ack outside RD_LO/RD_HI is ignored.
- Reset, including mid-operation:
  - State goes to IDLE.
  - All outputs go to 0, including ld_data.
  - Any in-flight read is abandoned; the next post-reset ack is ignored.

## Timing
- Zero-wait memory (ack in the same cycle as mem_req):
  - Byte load: ld_start in cycle 0 → mem_req in cycle 1 → ld_done in cycle 2.
  - Word load: ld_done in cycle 3.
- Each wait cycle per read adds 1 cycle of latency.
- mem_req stays high continuously from RD_LO through RD_HI. mem_addr changes in the cycle after the low-byte ack.
- mem_req=0 in DONE and IDLE.
- Back-to-back loads:
  - The earliest next accepted ld_start is the cycle after DONE.
  - Minimum issue interval: 3 cycles (byte), 4 cycles (word).
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- LD_SIGN_EXT_EN defined:
  - The ld_signed port exists.
  - A byte load with ld_signed=1 replicates bit 7 into bits 15:8.
  - With ld_signed=0, a byte load is zero-extended.
- LD_SIGN_EXT_EN undefined:
  - The ld_signed port is absent.
  - Byte loads are always zero-extended.
- Word loads are unaffected in either case.

## Structure
- Shared package bamf_mem_pkg holds:
  - State encodings: IDLE=2'd0, RD_LO=2'd1, RD_HI=2'd2, DONE=2'd3.
  - Default WAIT_MAX.
  - Byte-order constant (little-endian).
- One sub-module, byte_extender:
  - 8-bit in, 16-bit out, plus a sign-select input tied to 0 when the macro is off.
  - Purely combinational; instantiated once on the latched low byte.

## Test plan
- Reset mid-word-load (during RD_HI) → ld_busy=0, mem_req=0, ld_data=0 next cycle; a subsequent stray mem_ack produces no ld_done.
- Byte load, addr 0x1234, mem_rdata 0xA5, zero-wait → mem_addr=0x1234 in cycle 1, ld_done in cycle 2, ld_data=0x00A5 (0xFFA5 with LD_SIGN_EXT_EN and ld_signed=1).
- Word load, addr 0xFFFF, data 0x34 then 0x12, 2 wait cycles per read → second read at mem_addr=0x0000, ld_data=0x1234, ld_done 7 cycles after ld_start.
- Word load with no ack on the high byte, WAIT_MAX=15 → ld_done with ld_err=1, ld_data=0x0000, then IDLE; with ack on the 15th wait cycle instead → ld_err=0.
- ld_start held high continuously during a byte load → exactly one load per DONE→IDLE pass; second request accepted in the cycle after DONE.
